// File: rtl/fismos_mailbox_ctrl.sv
// fismos_mailbox_ctrl
// Host <-> PicoRV32 command mailbox. A host write of a correctly tagged
// control word rings the CPU doorbell and hands the shared buffers to the
// CPU. A watchdog bounds the execution time. Completion is reported through
// a status word and a level interrupt to the host, which stays high until
// the host acknowledges it.
//
// Parameter constraints (not checked in hardware):
//   TIMEOUT_CYCLES >= 2
//   CNT_W          >= clog2(TIMEOUT_CYCLES)
module fismos_mailbox_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 1000000,
   parameter logic [7:0]  CMD_MAGIC      = 8'hDF,
   parameter int unsigned CNT_W          = 32
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        ctrl_wr_en,
   input  logic [31:0] ctrl_wr_data,
   input  logic        host_irq_clr,
   input  logic        cpu_ack,
   input  logic        cpu_done,
   input  logic [7:0]  cpu_result,
   output logic        cpu_irq,
   output logic [15:0] cmd,
   output logic        buf_owner,
   output logic        busy,
   output logic        interrupt_to_linux,
   output logic [31:0] status_reg
);

   // The encoding is visible to the host through status_reg[1:0].
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DOORBELL = 2'd1,
      ST_EXEC     = 2'd2,
      ST_COMPLETE = 2'd3
   } state_e;

   // The watchdog expires on the cycle it holds this value, which puts the
   // forced completion exactly TIMEOUT_CYCLES cycles after acceptance.
   localparam logic [CNT_W-1:0] WD_LAST       = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] WD_ONE        = CNT_W'(1);
   localparam logic [7:0]       RES_BAD_MAGIC = 8'hFE;
   localparam logic [7:0]       RES_TIMEOUT   = 8'hFF;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] wd_q, wd_d;
   logic [15:0]      cmd_q, cmd_d;
   logic [7:0]       result_q, result_d;
   logic             bad_magic_q, bad_magic_d;
   logic             timeout_q, timeout_d;
   logic             overrun_q, overrun_d;
   logic             cpu_irq_q, cpu_irq_d;
   logic             buf_owner_q, buf_owner_d;
   logic             busy_q, busy_d;
   logic             irq_linux_q, irq_linux_d;
   logic [31:0]      status_q, status_d;

   // Bits [23:16] of the control word carry no meaning for this block.
   logic unused_ctrl_bits;
   assign unused_ctrl_bits = ^ctrl_wr_data[23:16];

   // Next-state, datapath and output decode for the mailbox handshake.
   always_comb begin
      // NOTE: every signal gets a default before the case so that no path
      // leaves a value unassigned; otherwise synthesis infers latches.
      state_d     = state_q;
      wd_d        = wd_q;
      cmd_d       = cmd_q;
      result_d    = result_q;
      bad_magic_d = bad_magic_q;
      timeout_d   = timeout_q;
      overrun_d   = overrun_q;

      case (state_q)
         ST_IDLE: begin
            if (ctrl_wr_en) begin
               // The command field is echoed even for a rejected word so the
               // host can see which write was refused.
               cmd_d = ctrl_wr_data[15:0];
               if (ctrl_wr_data[31:24] == CMD_MAGIC) begin
                  result_d    = 8'h00;
                  bad_magic_d = 1'b0;
                  timeout_d   = 1'b0;
                  overrun_d   = 1'b0;
                  wd_d        = '0;
                  state_d     = ST_DOORBELL;
               end else begin
                  bad_magic_d = 1'b1;
                  result_d    = RES_BAD_MAGIC;
                  state_d     = ST_COMPLETE;
               end
            end
         end

         ST_DOORBELL, ST_EXEC: begin
            if (ctrl_wr_en) begin
               overrun_d = 1'b1;
            end
            if (wd_q != '1) begin
               wd_d = wd_q + WD_ONE;
            end
            // cpu_done outranks both the watchdog and a pending ack; in the
            // doorbell state it also stands in for the missing ack.
            if (cpu_done) begin
               result_d = cpu_result;
               state_d  = ST_COMPLETE;
            end else if (wd_q == WD_LAST) begin
               timeout_d = 1'b1;
               result_d  = RES_TIMEOUT;
               state_d   = ST_COMPLETE;
            end else if (state_q == ST_DOORBELL && cpu_ack) begin
               state_d = ST_EXEC;
            end
         end

         ST_COMPLETE: begin
            if (ctrl_wr_en) begin
               overrun_d = 1'b1;
            end
            if (host_irq_clr) begin
               state_d = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase

      // Outputs are decoded from the next state and registered, so they line
      // up with the state register and carry no combinational glitches.
      cpu_irq_d   = (state_d == ST_DOORBELL);
      buf_owner_d = (state_d == ST_DOORBELL) || (state_d == ST_EXEC);
      busy_d      = (state_d != ST_IDLE);
      irq_linux_d = (state_d == ST_COMPLETE);
      status_d    = {cmd_d, result_d, 3'b000, overrun_d, timeout_d,
                     bad_magic_d, state_d};
   end

   // State, datapath and output registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= ST_IDLE;
         wd_q        <= '0;
         cmd_q       <= '0;
         result_q    <= '0;
         bad_magic_q <= 1'b0;
         timeout_q   <= 1'b0;
         overrun_q   <= 1'b0;
         cpu_irq_q   <= 1'b0;
         buf_owner_q <= 1'b0;
         busy_q      <= 1'b0;
         irq_linux_q <= 1'b0;
         status_q    <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the values
         // from before the edge, independent of statement order.
         state_q     <= state_d;
         wd_q        <= wd_d;
         cmd_q       <= cmd_d;
         result_q    <= result_d;
         bad_magic_q <= bad_magic_d;
         timeout_q   <= timeout_d;
         overrun_q   <= overrun_d;
         cpu_irq_q   <= cpu_irq_d;
         buf_owner_q <= buf_owner_d;
         busy_q      <= busy_d;
         irq_linux_q <= irq_linux_d;
         status_q    <= status_d;
      end
   end

   assign cpu_irq            = cpu_irq_q;
   assign cmd                = cmd_q;
   assign buf_owner          = buf_owner_q;
   assign busy               = busy_q;
   assign interrupt_to_linux = irq_linux_q;
   assign status_reg         = status_q;

endmodule

// File: tb/tb_fismos_mailbox_ctrl.sv
// Bench for fismos_mailbox_ctrl. Two instances share one stimulus stream:
// instance A has a long watchdog, so commands can run to normal completion.
// Instance B has TIMEOUT_CYCLES = 16, so the watchdog boundaries can be
// reached. A transaction-level reference model tracks both instances every
// cycle. Directed steps add literal checks, and a randomized phase follows.
module tb_fismos_mailbox_ctrl;

   localparam int T_A = 40;
   localparam int T_B = 16;

   logic        clk          = 1'b0;
   logic        resetn       = 1'b0;
   logic        ctrl_wr_en   = 1'b0;
   logic [31:0] ctrl_wr_data = '0;
   logic        host_irq_clr = 1'b0;
   logic        cpu_ack      = 1'b0;
   logic        cpu_done     = 1'b0;
   logic [7:0]  cpu_result   = '0;

   logic        a_cpu_irq, a_buf_owner, a_busy, a_intr;
   logic [15:0] a_cmd;
   logic [31:0] a_status;
   logic        b_cpu_irq, b_buf_owner, b_busy, b_intr;
   logic [15:0] b_cmd;
   logic [31:0] b_status;

   int    n_assert = 0;
   int    n_fail   = 0;
   string step     = "init";

   always #5 clk = ~clk;

   fismos_mailbox_ctrl #(.TIMEOUT_CYCLES(T_A), .CMD_MAGIC(8'hDF), .CNT_W(32)) u_dut_a (
      .clk(clk), .resetn(resetn), .ctrl_wr_en(ctrl_wr_en), .ctrl_wr_data(ctrl_wr_data),
      .host_irq_clr(host_irq_clr), .cpu_ack(cpu_ack), .cpu_done(cpu_done),
      .cpu_result(cpu_result), .cpu_irq(a_cpu_irq), .cmd(a_cmd), .buf_owner(a_buf_owner),
      .busy(a_busy), .interrupt_to_linux(a_intr), .status_reg(a_status));

   fismos_mailbox_ctrl #(.TIMEOUT_CYCLES(T_B), .CMD_MAGIC(8'hDF), .CNT_W(8)) u_dut_b (
      .clk(clk), .resetn(resetn), .ctrl_wr_en(ctrl_wr_en), .ctrl_wr_data(ctrl_wr_data),
      .host_irq_clr(host_irq_clr), .cpu_ack(cpu_ack), .cpu_done(cpu_done),
      .cpu_result(cpu_result), .cpu_irq(b_cpu_irq), .cmd(b_cmd), .buf_owner(b_buf_owner),
      .busy(b_busy), .interrupt_to_linux(b_intr), .status_reg(b_status));

   // Reference model, one slot per instance. Phase 0 = idle, 1 = doorbell
   // rung, 2 = executing, 3 = complete. age counts the edges spent waiting on the CPU.
   int          m_t   [2] = '{T_A, T_B};
   int          m_ph  [2];
   int          m_age [2];
   logic [15:0] m_cmd [2];
   logic [7:0]  m_res [2];
   logic        m_bad [2];
   logic        m_to  [2];
   logic        m_ov  [2];

   task automatic model_edge();
      for (int i = 0; i < 2; i++) begin
         if (!resetn) begin
            m_ph[i] = 0; m_age[i] = 0; m_cmd[i] = '0; m_res[i] = '0;
            m_bad[i] = 1'b0; m_to[i] = 1'b0; m_ov[i] = 1'b0;
         end else if (m_ph[i] == 0) begin
            if (ctrl_wr_en) begin
               m_cmd[i] = ctrl_wr_data[15:0];
               if (ctrl_wr_data[31:24] == 8'hDF) begin
                  m_ph[i] = 1; m_age[i] = 0; m_res[i] = 8'h00;
                  m_bad[i] = 1'b0; m_to[i] = 1'b0; m_ov[i] = 1'b0;
               end else begin
                  m_ph[i] = 3; m_bad[i] = 1'b1; m_res[i] = 8'hFE;
               end
            end
         end else if (m_ph[i] == 3) begin
            if (ctrl_wr_en) m_ov[i] = 1'b1;
            if (host_irq_clr) m_ph[i] = 0;
         end else begin
            if (ctrl_wr_en) m_ov[i] = 1'b1;
            if (cpu_done) begin
               m_res[i] = cpu_result; m_ph[i] = 3;
            end else if (m_age[i] + 1 == m_t[i]) begin
               m_to[i] = 1'b1; m_res[i] = 8'hFF; m_ph[i] = 3;
            end else if (m_ph[i] == 1 && cpu_ack) begin
               m_ph[i] = 2;
            end
            m_age[i]++;
         end
      end
   endtask

   function automatic logic [63:0] exp_vec(int i);
      logic [31:0] st;
      st = {m_cmd[i], m_res[i], 3'b000, m_ov[i], m_to[i], m_bad[i], 2'(m_ph[i])};
      return {12'h000, st, m_cmd[i], (m_ph[i] == 1), (m_ph[i] == 1 || m_ph[i] == 2),
              (m_ph[i] != 0), (m_ph[i] == 3)};
   endfunction

   function automatic logic [63:0] obs_vec(int i);
      if (i == 0) return {12'h000, a_status, a_cmd, a_cpu_irq, a_buf_owner, a_busy, a_intr};
      return {12'h000, b_status, b_cmd, b_cpu_irq, b_buf_owner, b_busy, b_intr};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   // One clock: the model consumes the inputs sampled at the edge, then both
   // instances are compared 1 ns later, well away from the edge.
   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check({step, "/a"}, obs_vec(0), exp_vec(0));
      check({step, "/b"}, obs_vec(1), exp_vec(1));
   endtask

   task automatic write_cmd(input logic [31:0] w);
      ctrl_wr_en = 1'b1; ctrl_wr_data = w; tick(); ctrl_wr_en = 1'b0;
   endtask

   task automatic host_clear();
      host_irq_clr = 1'b1; tick(); host_irq_clr = 1'b0;
   endtask

   task automatic finish_cpu(input logic [7:0] r);
      cpu_done = 1'b1; cpu_result = r; tick(); cpu_done = 1'b0;
   endtask

   initial begin
      int irq_cnt;

      // Reset state
      step = "reset";
      model_edge();
      #3;
      check("reset/a_zero", obs_vec(0), 64'h0);
      check("reset/b_zero", obs_vec(1), 64'h0);
      tick();
      tick();
      resetn = 1'b1;
      tick();

      // Normal handshake on A: cpu_irq is high until the ack edge, and the
      // completion is reported one cycle after done.
      step = "basic";
      write_cmd(32'hDF00_0001);
      irq_cnt = int'(a_cpu_irq);
      check("basic/busy_owner", 64'({a_busy, a_buf_owner}), 64'h3);
      repeat (5) begin tick(); irq_cnt += int'(a_cpu_irq); end
      cpu_ack = 1'b1; tick(); cpu_ack = 1'b0;
      irq_cnt += int'(a_cpu_irq);
      check("basic/irq_cycles", 64'(irq_cnt), 64'd6);
      repeat (13) tick();
      check("basic/intr_before_done", 64'(a_intr), 64'h0);
      finish_cpu(8'h00);
      check("basic/intr_after_done", 64'(a_intr), 64'h1);
      check("basic/status_complete", 64'(a_status), 64'h0001_0003);
      host_clear();
      check("basic/status_cleared", 64'(a_status), 64'h0001_0000);
      check("basic/idle_outputs", 64'({a_buf_owner, a_busy, a_intr}), 64'h0);

      // Wrong magic goes straight to completion without ringing the CPU.
      step = "bad_magic";
      write_cmd(32'hAB00_0007);
      check("bad_magic/status", 64'(a_status), 64'h0007_FE07);
      check("bad_magic/no_irq", 64'(a_cpu_irq), 64'h0);
      tick();
      check("bad_magic/still_no_irq", 64'(a_cpu_irq), 64'h0);
      host_clear();

      // Watchdog expiry on B exactly 16 cycles after acceptance.
      step = "timeout";
      write_cmd(32'hDF00_0002);
      repeat (15) tick();
      check("timeout/not_yet", 64'(b_status[1:0]), 64'h1);
      tick();
      check("timeout/status", 64'(b_status), 64'h0002_FF0B);
      check("timeout/intr", 64'({b_intr, b_cpu_irq, b_buf_owner}), 64'h4);
      finish_cpu(8'h11);
      host_clear();

      // A write during execution is dropped and flagged as overrun.
      step = "overrun";
      write_cmd(32'hDF00_0001);
      cpu_ack = 1'b1; tick(); cpu_ack = 1'b0;
      write_cmd(32'hDF00_0009);
      check("overrun/cmd_kept", 64'(a_cmd), 64'h0001);
      check("overrun/flag", 64'(a_status[4]), 64'h1);
      check("overrun/still_exec", 64'(a_status[1:0]), 64'h2);
      finish_cpu(8'h33);
      host_clear();
      check("overrun/sticky", 64'(a_status), 64'h0001_3310);

      // cpu_done lands on B's expiry edge while still in doorbell: done wins.
      step = "done_on_expiry";
      write_cmd(32'hDF00_0004);
      check("done_on_expiry/ov_cleared_a", 64'(a_status[4]), 64'h0);
      check("done_on_expiry/ov_cleared_b", 64'(b_status[4]), 64'h0);
      repeat (15) tick();
      finish_cpu(8'h5A);
      check("done_on_expiry/status_b", 64'(b_status), 64'h0004_5A03);
      host_clear();

      // Asynchronous reset while executing, then a clean restart.
      step = "reset_exec";
      write_cmd(32'hDF00_0005);
      cpu_ack = 1'b1; tick(); cpu_ack = 1'b0;
      check("reset_exec/in_exec", 64'(a_status[1:0]), 64'h2);
      #1 resetn = 1'b0;
      #1;
      check("reset_exec/a_async_zero", obs_vec(0), 64'h0);
      check("reset_exec/b_async_zero", obs_vec(1), 64'h0);
      tick();
      resetn = 1'b1;
      write_cmd(32'hDF00_0003);
      check("reset_exec/restart_status", 64'(a_status), 64'h0003_0001);
      check("reset_exec/restart_flags", 64'({a_cpu_irq, a_busy, a_buf_owner}), 64'h7);
      finish_cpu(8'h01);
      host_clear();

      // Randomized traffic, including occasional asynchronous resets.
      step = "random";
      repeat (3000) begin
         ctrl_wr_en   = ($urandom_range(7) == 0);
         ctrl_wr_data = {(($urandom_range(3) == 0) ? 8'($urandom) : 8'hDF),
                         8'($urandom), 16'($urandom)};
         host_irq_clr = ($urandom_range(5) == 0);
         cpu_ack      = ($urandom_range(4) == 0);
         cpu_done     = ($urandom_range(11) == 0);
         cpu_result   = 8'($urandom);
         resetn       = ($urandom_range(299) != 0);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
